gray_step_counter: RTL and testbench

- Sequential source stage that sits directly upstream of the quad-XOR Gray code converter on Basys3.
- Produces a stepping binary count and its registered Gray-code image. Either bus drives the converter inputs; the binary bus is also the golden value for comparison against the converter output.
- A built-in prescaler sets the step rate, so LEDs can show slow, human-visible steps while simulation uses a tiny divider.

---
 rtl/gray_step_counter.sv | 80 ++++++++
 tb/tb_gray_step_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gray_step_counter.sv
// Prescaled up/down binary counter with a registered Gray-code image, used as
// the stimulus source for the quad-XOR Gray converter.
module gray_step_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 100000000,
    parameter int unsigned PW    = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tick,
    output logic             wrap
);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] BIN_MAX    = '1;
    localparam logic [WIDTH-1:0] BIN_ZERO   = '0;

    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_nxt;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic [WIDTH-1:0] step_bin;
    logic             tick_nxt;
    logic             wrap_nxt;
    logic             step_c;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Next-state: load beats step beats hold; gray is derived from the same
    // next binary value so both buses update together.
    always_comb begin
        presc_nxt = presc;
        bin_nxt   = bin_out;
        gray_nxt  = gray_out;
        tick_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        step_c    = en && (presc == PRESC_LAST);
        step_bin  = up_dn ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));

        if (en) begin
            presc_nxt = step_c ? '0 : (presc + PW'(1));
        end

        if (load) begin
            bin_nxt   = load_val;
            gray_nxt  = to_gray(load_val);
            presc_nxt = '0;
        end else if (step_c) begin
            bin_nxt  = step_bin;
            gray_nxt = to_gray(step_bin);
            tick_nxt = 1'b1;
            wrap_nxt = up_dn ? (bin_out == BIN_MAX) : (bin_out == BIN_ZERO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            bin_out  <= '0;
            gray_out <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            presc    <= presc_nxt;
            bin_out  <= bin_nxt;
            gray_out <= gray_nxt;
            tick     <= tick_nxt;
            wrap     <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_step_counter.sv
// Directed, table-driven bench for gray_step_counter (DIV=4 instance) plus a
// random up/down scoreboard run on a DIV=1 instance.
module tb_gray_step_counter;

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       tick;
        logic       wrap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] bin_out, gray_out;
    logic       tick, wrap;

    logic       en_b, up_b;
    logic       load_b = 1'b0;
    logic [3:0] load_val_b = 4'd0;
    logic [3:0] bin_b, gray_b;
    logic       tick_b, wrap_b;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    logic [3:0] gray_tab [16];

    always #5 clk = ~clk;

    gray_step_counter #(.WIDTH(4), .DIV(4), .PW(3)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bin_out(bin_out), .gray_out(gray_out),
        .tick(tick), .wrap(wrap)
    );

    gray_step_counter #(.WIDTH(4), .DIV(1), .PW(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .load(load_b),
        .load_val(load_val_b), .bin_out(bin_b), .gray_out(gray_b),
        .tick(tick_b), .wrap(wrap_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input int n, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input logic [3:0] b, input logic [3:0] g,
                       input logic t, input logic w);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{en: e, up_dn: u, load: l, load_val: lv,
                             bin: b, gray: g, tick: t, wrap: w});
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] b, input logic [3:0] g,
                              input logic t, input logic w);
        check({tag, " bin"},  32'(bin_out),  32'(b));
        check({tag, " gray"}, 32'(gray_out), 32'(g));
        check({tag, " tick"}, 32'(tick),     32'(t));
        check({tag, " wrap"}, 32'(wrap),     32'(w));
    endtask

    initial begin
        logic [3:0] bidx;
        logic [3:0] prev_bin, prev_gray, exp_bin;
        logic       exp_wrap;

        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Up count through a full wrap: one step per four enabled edges.
        for (int k = 1; k <= 64; k++) begin
            bidx = 4'((k / 4) % 16);
            add(1, 1'b1, 1'b1, 1'b0, 4'd0, bidx, gray_tab[bidx], (k % 4) == 0, k == 64);
        end
        // Down from zero wraps to 15, then 14.
        add(3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  4'b0000, 1'b0, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b1);
        add(3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15, 4'b1000, 1'b0, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd14, 4'b1001, 1'b1, 1'b0);
        // Load lands on the step edge and suppresses it.
        add(3, 1'b1, 1'b1, 1'b0, 4'd0,  4'd14, 4'b1001, 1'b0, 1'b0);
        add(1, 1'b1, 1'b1, 1'b1, 4'hA,  4'd10, 4'b1111, 1'b0, 1'b0);
        add(3, 1'b1, 1'b1, 1'b0, 4'd0,  4'd10, 4'b1111, 1'b0, 1'b0);
        add(1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd11, 4'b1110, 1'b1, 1'b0);
        // Freeze with presc at 2, then two more enabled edges to step.
        add(2,  1'b1, 1'b1, 1'b0, 4'd0, 4'd11, 4'b1110, 1'b0, 1'b0);
        add(10, 1'b0, 1'b1, 1'b0, 4'd0, 4'd11, 4'b1110, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 1'b0, 4'd0, 4'd11, 4'b1110, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 1'b0, 4'd0, 4'd12, 4'b1010, 1'b1, 1'b0);
        // Load while disabled, then count up to 7.
        add(1, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 4'b0111, 1'b0, 1'b0);
        add(3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 4'b0111, 1'b0, 1'b0);
        add(1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 4'b0101, 1'b1, 1'b0);
        add(3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 4'b0101, 1'b0, 1'b0);
        add(1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd7, 4'b0100, 1'b1, 1'b0);

        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        en_b = 1'b0; up_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            en = vecs[i].en; up_dn = vecs[i].up_dn;
            load = vecs[i].load; load_val = vecs[i].load_val;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].bin, vecs[i].gray, vecs[i].tick, vecs[i].wrap);
        end
        load = 1'b0; en = 1'b1; up_dn = 1'b1;

        // Asynchronous reset between edges at bin=7, presc=2.
        repeat (2) @(posedge clk);
        #1;
        check_outs("pre_rst", 4'd7, 4'b0100, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_outs("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check_outs($sformatf("post_rst%0d", k), (k == 4) ? 4'd1 : 4'd0,
                       (k == 4) ? 4'b0001 : 4'b0000, k == 4, 1'b0);
        end
        en = 1'b0;

        // DIV=1 instance: step every cycle with random direction.
        check("b_idle bin", 32'(bin_b), 32'd0);
        prev_bin = bin_b; prev_gray = gray_b;
        for (int i = 0; i < 1000; i++) begin
            en_b = 1'b1;
            up_b = 1'($urandom_range(0, 1));
            exp_bin  = up_b ? prev_bin + 4'd1 : prev_bin - 4'd1;
            exp_wrap = up_b ? (prev_bin == 4'd15) : (prev_bin == 4'd0);
            @(posedge clk);
            #1;
            check($sformatf("b%0d bin", i),   32'(bin_b),  32'(exp_bin));
            check($sformatf("b%0d gray", i),  32'(gray_b), 32'(bin_b ^ (bin_b >> 1)));
            check($sformatf("b%0d hamming", i), 32'($countones(gray_b ^ prev_gray)), 32'd1);
            check($sformatf("b%0d tick", i),  32'(tick_b), 32'd1);
            check($sformatf("b%0d wrap", i),  32'(wrap_b), 32'(exp_wrap));
            prev_bin = bin_b; prev_gray = gray_b;
        end
        en_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
